// File: rtl/clock_tick_gen_if.sv
// Control and output bundle for clock_tick_gen: count control, ratio write port and per-channel tick/lvl.
interface clock_tick_gen_if #(
  parameter int N_CH  = 3,
  parameter int CNT_W = 17,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  // Strobe semantics, no backpressure: en, sync and wr_en are sampled on every
  // rising clk edge; wr_ch/wr_div only matter while wr_en is high, and a write
  // always completes on the edge that samples it. tick/lvl are registered.
  logic             en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  lvl;

  modport master (
    output en, sync, wr_en, wr_ch, wr_div,
    input  tick, lvl
  );

  modport slave (
    input  en, sync, wr_en, wr_ch, wr_div,
    output tick, lvl
  );
endinterface

// File: rtl/clock_tick_gen.sv
// N_CH programmable clock dividers emitting one-cycle ticks and optional 50% square waves.
// Define CLOCK_TICK_GEN_LVL_EN to build the lvl toggle flops; otherwise lvl is tied to 0.
module clock_tick_gen #(
  parameter int N_CH    = 3,
  parameter int CNT_W   = 17,
  parameter int DEF_DIV = 2,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input logic             clk,
  input logic             clr,
  clock_tick_gen_if.slave bus
);

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t            div_q [N_CH];
  cnt_t            div_d [N_CH];
  cnt_t            cnt_q [N_CH];
  cnt_t            cnt_d [N_CH];
  logic [N_CH-1:0] tick_q;
  logic [N_CH-1:0] tick_d;
  logic [N_CH-1:0] wr_hit;

`ifdef CLOCK_TICK_GEN_LVL_EN
  logic [N_CH-1:0] lvl_q;
  logic [N_CH-1:0] lvl_d;
`endif

  // Out-of-range channel numbers never match any index, so such writes are dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
    end
  end

  always_comb begin
    tick_d = '0;
`ifdef CLOCK_TICK_GEN_LVL_EN
    lvl_d  = lvl_q;
`endif
    for (int i = 0; i < N_CH; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = cnt_q[i];
      if (wr_hit[i]) begin
        div_d[i] = bus.wr_div;
      end
      // A restart (write or sync) beats counting, even on the wrap edge.
      if (wr_hit[i] || bus.sync || (div_q[i] == '0)) begin
        cnt_d[i] = '0;
`ifdef CLOCK_TICK_GEN_LVL_EN
        lvl_d[i] = 1'b0;
`endif
      end else if (bus.en) begin
        if (cnt_q[i] == div_q[i] - cnt_t'(1)) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
`ifdef CLOCK_TICK_GEN_LVL_EN
          lvl_d[i]  = ~lvl_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        div_q[i] <= cnt_t'(DEF_DIV);
        cnt_q[i] <= '0;
      end
      tick_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      tick_q <= tick_d;
    end
  end

`ifdef CLOCK_TICK_GEN_LVL_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign bus.lvl = lvl_q;
`else
  assign bus.lvl = '0;
`endif

  assign bus.tick = tick_q;

endmodule
